rx_deframer: RTL and testbench
==============================

RX_DEFRAMER -- requirements
Module: rx_deframer

Interface
REQ-001 The block SHALL have parameter MAX_PAYLOAD, default 16, meaning the maximum number of data bytes accepted per packet (range 1..255).
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low: clk  input  1  rising-edge clock.
REQ-003 n_rst  input  1  asynchronous active-low reset.
REQ-004 byte_ready  input  1  single-cycle strobe; rx_byte holds a new received byte.
REQ-005 rx_byte  input  8  received byte, valid only when byte_ready=1.
REQ-006 data_out  output  8  registered payload byte.
REQ-007 data_valid  output  1  one-cycle strobe; data_out holds a new payload byte.
REQ-008 packet_done  output  1  one-cycle strobe; a well-formed packet ended.
REQ-009 framing_error  output  1  sticky error flag; cleared by next SOF or reset.
REQ-010 rx_active  output  1  high while inside a packet (state PAYLOAD).

Function
REQ-011 Framing constants SHALL be SOF = 8'hAA and EOF = 8'hBB.
REQ-012 States SHALL be IDLE, PAYLOAD, DONE, ERROR.
REQ-013 IDLE: byte_ready with SOF -> PAYLOAD, len cleared, framing_error cleared; any other byte ignored, stay IDLE.
REQ-014 PAYLOAD with byte_ready and non-framing byte, len < MAX_PAYLOAD: data_out <= rx_byte, data_valid=1 next cycle, len+1.
REQ-015 PAYLOAD with byte_ready and EOF -> DONE; packet_done=1 for exactly the cycle in DONE.
REQ-016 DONE -> IDLE unconditionally after one cycle; a byte_ready during DONE is processed as in IDLE.
REQ-017 Empty packet (SOF immediately followed by EOF) SHALL be legal: packet_done pulses, no data_valid.
REQ-018 PAYLOAD with byte_ready and SOF (resync) SHALL set framing_error, restart PAYLOAD with len=0, no packet_done.
REQ-019 PAYLOAD with byte_ready, non-framing byte, len == MAX_PAYLOAD -> ERROR, framing_error=1, no data_valid.
REQ-020 ERROR: discard bytes until SOF -> PAYLOAD (clears framing_error); EOF in ERROR -> IDLE, framing_error stays set.
REQ-021 Latency: every output SHALL change on the clock edge after the edge sampling byte_ready; byte_ready=0 causes no state change.
REQ-022 Payload counter SHALL be 8 bits, saturating conceptually at MAX_PAYLOAD; no wrap-around possible.
REQ-023 Back-to-back byte_ready on consecutive cycles SHALL be accepted without loss.

Reset
REQ-024 On n_rst=0, asynchronously: state=IDLE, data_out=8'h00, data_valid=0, packet_done=0, framing_error=0, rx_active=0, len=0.
REQ-025 Reset mid-packet SHALL abandon the packet with no packet_done or data_valid afterward until a new SOF.

Configuration
REQ-026 Macro RX_DEFRAMER_LEN_EN defined: extra output pkt_len  output  8, holding the payload count of the last completed packet, updated the cycle packet_done asserts, reset 8'h00.
REQ-027 Macro RX_DEFRAMER_LEN_EN undefined: pkt_len port and its register SHALL not exist; all other behaviour identical.

Structure
REQ-028 Package rx_pkg SHALL hold SOF_BYTE, EOF_BYTE constants and the rx_state_t enum (IDLE, PAYLOAD, DONE, ERROR).
REQ-029 One sub-module rx_len_counter (clear, enable, 8-bit count, at_max flag against MAX_PAYLOAD) SHALL implement the payload counter.

Verification
REQ-030 Reset: n_rst=0 mid-PAYLOAD -> state IDLE, all outputs 0 immediately, no strobes after release.
REQ-031 Normal: AA,11,22,BB -> data_valid with 11 then 22, packet_done one cycle after BB, pkt_len=2 (LEN_EN).
REQ-032 Empty/idle noise: 55,BB,AA,BB -> no data_valid, one packet_done, framing_error=0, pkt_len=0.
REQ-033 Overflow (MAX_PAYLOAD=4): AA,01..05,BB -> four data_valid, framing_error=1 on 5th, no packet_done, state IDLE after BB.
REQ-034 Resync: AA,11,AA,22,BB -> framing_error=1 after second AA, data_valid 11 and 22, packet_done after BB, pkt_len=1.
REQ-035 Back-to-back: AA,33,44,BB on consecutive cycles -> two data_valid on consecutive cycles, then packet_done; AA arriving in DONE cycle starts next packet.

Source files
------------

// File: rtl/rx_pkg.sv
// Shared framing constants and state encoding for the byte-stream deframer.
package rx_pkg;

  localparam logic [7:0] SOF_BYTE = 8'hAA;
  localparam logic [7:0] EOF_BYTE = 8'hBB;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    DONE    = 2'd2,
    ERROR   = 2'd3
  } rx_state_t;

endpackage

// File: rtl/rx_len_counter.sv
// Payload byte counter: synchronous clear, increment on enable, saturates at MAX_PAYLOAD.
module rx_len_counter #(
  parameter int unsigned MAX_PAYLOAD = 16
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       clear,
  input  logic       enable,
  output logic [7:0] count,
  output logic       at_max
);

  localparam logic [7:0] MAX_LEN = 8'(MAX_PAYLOAD);

  assign at_max = (count == MAX_LEN);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !at_max) begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/rx_deframer.sv
// Extracts payload bytes framed by SOF/EOF from a received byte stream.
// Define RX_DEFRAMER_LEN_EN to add the pkt_len output (payload length of last good packet).
module rx_deframer
  import rx_pkg::*;
#(
  parameter int unsigned MAX_PAYLOAD = 16
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       byte_ready,
  input  logic [7:0] rx_byte,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       packet_done,
  output logic       framing_error,
  output logic       rx_active
`ifdef RX_DEFRAMER_LEN_EN
  ,
  output logic [7:0] pkt_len
`endif
);

  rx_state_t  state;
  rx_state_t  state_nxt;
  logic [7:0] data_nxt;
  logic       valid_nxt;
  logic       error_nxt;
  logic       len_clear;
  logic       len_inc;
  logic       at_max;

`ifdef RX_DEFRAMER_LEN_EN
  logic [7:0] len;
`else
  logic [7:0] len_unused;
`endif

  rx_len_counter #(
    .MAX_PAYLOAD (MAX_PAYLOAD)
  ) u_len (
    .clk    (clk),
    .n_rst  (n_rst),
    .clear  (len_clear),
    .enable (len_inc),
`ifdef RX_DEFRAMER_LEN_EN
    .count  (len),
`else
    .count  (len_unused),
`endif
    .at_max (at_max)
  );

  // DONE always falls back to IDLE, but a byte in that cycle is still decoded as in IDLE.
  always_comb begin
    state_nxt = (state == DONE) ? IDLE : state;
    data_nxt  = data_out;
    valid_nxt = 1'b0;
    error_nxt = framing_error;
    len_clear = 1'b0;
    len_inc   = 1'b0;
    if (byte_ready) begin
      unique case (state)
        IDLE, DONE: begin
          if (rx_byte == SOF_BYTE) begin
            state_nxt = PAYLOAD;
            len_clear = 1'b1;
            error_nxt = 1'b0;
          end
        end
        PAYLOAD: begin
          if (rx_byte == SOF_BYTE) begin
            len_clear = 1'b1;
            error_nxt = 1'b1;
          end else if (rx_byte == EOF_BYTE) begin
            state_nxt = DONE;
          end else if (at_max) begin
            state_nxt = ERROR;
            error_nxt = 1'b1;
          end else begin
            data_nxt  = rx_byte;
            valid_nxt = 1'b1;
            len_inc   = 1'b1;
          end
        end
        ERROR: begin
          if (rx_byte == SOF_BYTE) begin
            state_nxt = PAYLOAD;
            len_clear = 1'b1;
            error_nxt = 1'b0;
          end else if (rx_byte == EOF_BYTE) begin
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state         <= IDLE;
      data_out      <= '0;
      data_valid    <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      state         <= state_nxt;
      data_out      <= data_nxt;
      data_valid    <= valid_nxt;
      framing_error <= error_nxt;
    end
  end

  assign packet_done = (state == DONE);
  assign rx_active   = (state == PAYLOAD);

`ifdef RX_DEFRAMER_LEN_EN
  // Captured on the same edge that enters DONE, so it is valid alongside packet_done.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pkt_len <= '0;
    end else if (state_nxt == DONE) begin
      pkt_len <= len;
    end
  end
`endif

endmodule

// File: tb/tb_rx_deframer.sv
// Directed self-checking bench for rx_deframer (MAX_PAYLOAD=4 to reach overflow quickly).
module tb_rx_deframer;

  logic       clk;
  logic       n_rst;
  logic       byte_ready;
  logic [7:0] rx_byte;
  logic [7:0] data_out;
  logic       data_valid;
  logic       packet_done;
  logic       framing_error;
  logic       rx_active;
`ifdef RX_DEFRAMER_LEN_EN
  logic [7:0] pkt_len;
`endif

  int n_checks = 0;
  int n_fails  = 0;
  int dv_cnt   = 0;
  int pd_cnt   = 0;
  int dv_snap;
  int pd_snap;

  rx_deframer #(
    .MAX_PAYLOAD (4)
  ) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .byte_ready    (byte_ready),
    .rx_byte       (rx_byte),
    .data_out      (data_out),
    .data_valid    (data_valid),
    .packet_done   (packet_done),
    .framing_error (framing_error),
    .rx_active     (rx_active)
`ifdef RX_DEFRAMER_LEN_EN
    ,
    .pkt_len       (pkt_len)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (data_valid)  dv_cnt <= dv_cnt + 1;
    if (packet_done) pd_cnt <= pd_cnt + 1;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one byte for exactly one rising edge; returns at the following falling edge.
  task automatic drive(input logic [7:0] b);
    byte_ready = 1'b1;
    rx_byte    = b;
    @(negedge clk);
    byte_ready = 1'b0;
    rx_byte    = 8'h00;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic expect_out(input string tag, input logic dv, input logic [7:0] d,
                            input logic pd, input logic fe, input logic act);
    check({tag, ".dv"},  int'(data_valid),    int'(dv));
    if (dv) check({tag, ".data"}, int'(data_out), int'(d));
    check({tag, ".pd"},  int'(packet_done),   int'(pd));
    check({tag, ".fe"},  int'(framing_error), int'(fe));
    check({tag, ".act"}, int'(rx_active),     int'(act));
  endtask

  initial begin
    n_rst      = 1'b0;
    byte_ready = 1'b0;
    rx_byte    = 8'h00;
    idle(2);
    check("rst.data", int'(data_out), 0);
    expect_out("rst", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
`ifdef RX_DEFRAMER_LEN_EN
    check("rst.len", int'(pkt_len), 0);
`endif
    n_rst = 1'b1;
    idle(1);

    // Normal packet with an idle gap mid-payload
    drive(8'hAA); expect_out("n.sof", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    drive(8'h11); expect_out("n.b1",  1'b1, 8'h11, 1'b0, 1'b0, 1'b1);
    idle(2);      expect_out("n.gap", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    drive(8'h22); expect_out("n.b2",  1'b1, 8'h22, 1'b0, 1'b0, 1'b1);
    drive(8'hBB); expect_out("n.eof", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
`ifdef RX_DEFRAMER_LEN_EN
    check("n.len", int'(pkt_len), 2);
`endif
    idle(1);      expect_out("n.end", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check("n.dvcnt", dv_cnt, 2);
    check("n.pdcnt", pd_cnt, 1);

    // Idle noise then an empty packet
    dv_snap = dv_cnt; pd_snap = pd_cnt;
    drive(8'h55); expect_out("e.noise", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    drive(8'hBB); expect_out("e.eof0",  1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    drive(8'hAA); expect_out("e.sof",   1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    drive(8'hBB); expect_out("e.eof",   1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
`ifdef RX_DEFRAMER_LEN_EN
    check("e.len", int'(pkt_len), 0);
`endif
    idle(1);
    check("e.dvcnt", dv_cnt - dv_snap, 0);
    check("e.pdcnt", pd_cnt - pd_snap, 1);

    // Overflow at MAX_PAYLOAD=4
    dv_snap = dv_cnt; pd_snap = pd_cnt;
    drive(8'hAA);
    for (int i = 1; i <= 4; i++) begin
      drive(8'(i));
      expect_out($sformatf("o.b%0d", i), 1'b1, 8'(i), 1'b0, 1'b0, 1'b1);
    end
    drive(8'h05); expect_out("o.ovf", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check("o.hold", int'(data_out), 8'h04);
    drive(8'h77); expect_out("o.disc", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    drive(8'hBB); expect_out("o.eof", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    idle(1);
    check("o.dvcnt", dv_cnt - dv_snap, 4);
    check("o.pdcnt", pd_cnt - pd_snap, 0);

    // Resync on SOF inside a packet
    dv_snap = dv_cnt; pd_snap = pd_cnt;
    drive(8'hAA); expect_out("r.sof1", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    drive(8'h11); expect_out("r.b1",   1'b1, 8'h11, 1'b0, 1'b0, 1'b1);
    drive(8'hAA); expect_out("r.sof2", 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    drive(8'h22); expect_out("r.b2",   1'b1, 8'h22, 1'b0, 1'b1, 1'b1);
    drive(8'hBB); expect_out("r.eof",  1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
`ifdef RX_DEFRAMER_LEN_EN
    check("r.len", int'(pkt_len), 1);
`endif
    idle(1);
    check("r.dvcnt", dv_cnt - dv_snap, 2);
    check("r.pdcnt", pd_cnt - pd_snap, 1);

    // Back-to-back packets, second SOF lands in the DONE cycle
    drive(8'hAA); expect_out("b.sof",  1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    drive(8'h33); expect_out("b.b1",   1'b1, 8'h33, 1'b0, 1'b0, 1'b1);
    drive(8'h44); expect_out("b.b2",   1'b1, 8'h44, 1'b0, 1'b0, 1'b1);
    drive(8'hBB); expect_out("b.eof",  1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
`ifdef RX_DEFRAMER_LEN_EN
    check("b.len1", int'(pkt_len), 2);
`endif
    drive(8'hAA); expect_out("b.sof2", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    drive(8'h55); expect_out("b.b3",   1'b1, 8'h55, 1'b0, 1'b0, 1'b1);
    drive(8'hBB); expect_out("b.eof2", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
`ifdef RX_DEFRAMER_LEN_EN
    check("b.len2", int'(pkt_len), 1);
`endif
    idle(1);

    // Asynchronous reset mid-packet
    drive(8'hAA);
    drive(8'h66); expect_out("x.pre", 1'b1, 8'h66, 1'b0, 1'b0, 1'b1);
    n_rst = 1'b0;
    #1;
    check("x.data", int'(data_out), 0);
    expect_out("x.rst", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
`ifdef RX_DEFRAMER_LEN_EN
    check("x.len", int'(pkt_len), 0);
`endif
    idle(2);
    n_rst = 1'b1;
    dv_snap = dv_cnt; pd_snap = pd_cnt;
    drive(8'h77);
    drive(8'hBB);
    idle(3);
    expect_out("x.post", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check("x.dvcnt", dv_cnt - dv_snap, 0);
    check("x.pdcnt", pd_cnt - pd_snap, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
